// File: rtl/kgp_isa_pkg.sv
// Shared KGP-RISC ISA encodings: opcodes, R-type function codes, control field
// encodings and the multi-cycle controller state set.
package kgp_isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00001;
    localparam logic [4:0] OP_COMPI = 5'b00010;
    localparam logic [4:0] OP_LW    = 5'b00011;
    localparam logic [4:0] OP_SW    = 5'b00100;
    localparam logic [4:0] OP_B     = 5'b00101;
    localparam logic [4:0] OP_BL    = 5'b00110;
    localparam logic [4:0] OP_BR    = 5'b00111;
    localparam logic [4:0] OP_BLTZ  = 5'b01000;
    localparam logic [4:0] OP_BZ    = 5'b01001;
    localparam logic [4:0] OP_BNZ   = 5'b01010;
    localparam logic [4:0] OP_BCY   = 5'b01011;
    localparam logic [4:0] OP_BNCY  = 5'b01100;

    localparam logic [4:0] FN_ADD   = 5'b00000;
    localparam logic [4:0] FN_COMP  = 5'b00001;
    localparam logic [4:0] FN_AND   = 5'b00010;
    localparam logic [4:0] FN_XOR   = 5'b00011;
    localparam logic [4:0] FN_SHLL  = 5'b00100;
    localparam logic [4:0] FN_SHRL  = 5'b00101;
    localparam logic [4:0] FN_SHLLV = 5'b00110;
    localparam logic [4:0] FN_SHRLV = 5'b00111;
    localparam logic [4:0] FN_SHRA  = 5'b01000;
    localparam logic [4:0] FN_SHRAV = 5'b01001;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_COMP  = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_XOR   = 3'b011;
    localparam logic [2:0] ALU_SHL   = 3'b100;
    localparam logic [2:0] ALU_SHRL  = 3'b101;
    localparam logic [2:0] ALU_SHRA  = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] SRC_RT    = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;

    localparam logic [1:0] PC_INC   = 2'b00;
    localparam logic [1:0] PC_LABEL = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_FWAIT  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_MWAIT  = 3'd5,
        ST_WB     = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    function automatic logic is_legal(input logic [4:0] op, input logic [4:0] fn);
        if (op == OP_RTYPE) begin
            return (fn <= FN_SHRAV);
        end else begin
            return (op <= OP_BNCY);
        end
    endfunction

    function automatic logic [2:0] rtype_alu_op(input logic [4:0] fn);
        case (fn)
            FN_ADD:             return ALU_ADD;
            FN_COMP:            return ALU_COMP;
            FN_AND:             return ALU_AND;
            FN_XOR:             return ALU_XOR;
            FN_SHLL, FN_SHLLV:  return ALU_SHL;
            FN_SHRL, FN_SHRLV:  return ALU_SHRL;
            FN_SHRA, FN_SHRAV:  return ALU_SHRA;
            default:            return ALU_PASSB;
        endcase
    endfunction

    // Constant-amount shifts take operand B from the shamt field.
    function automatic logic [1:0] rtype_alu_src(input logic [4:0] fn);
        case (fn)
            FN_SHLL, FN_SHRL, FN_SHRA: return SRC_SHAMT;
            default:                   return SRC_RT;
        endcase
    endfunction

endpackage

// File: rtl/kgp_control_fsm_if.sv
// Control interface between the KGP-RISC controller (master) and datapath (slave).
interface kgp_control_fsm_if;
    logic [4:0] opcode;
    logic [4:0] funccode;
    logic       zeroFlag;
    logic       negFlag;
    logic       carryFlag;
    logic [2:0] ALUResOp;
    logic [1:0] ALUSrc;
    logic       ALUFrc;
    logic       brLink;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       branch;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       irWrite;
    logic       flagWrite;
    logic       illegal;

    modport master (
        input  opcode, funccode, zeroFlag, negFlag, carryFlag,
        output ALUResOp, ALUSrc, ALUFrc, brLink, memToReg, memRead, memWrite,
               regWrite, branch, pcSrc, pcWrite, irWrite, flagWrite, illegal
    );

    modport slave (
        output opcode, funccode, zeroFlag, negFlag, carryFlag,
        input  ALUResOp, ALUSrc, ALUFrc, brLink, memToReg, memRead, memWrite,
               regWrite, branch, pcSrc, pcWrite, irWrite, flagWrite, illegal
    );
endinterface

// File: rtl/kgp_branch_cond.sv
// Branch condition evaluation from a registered opcode and the datapath flags.
module kgp_branch_cond
    import kgp_isa_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       zero_flag,
    input  logic       neg_flag,
    input  logic       carry_flag,
    output logic       taken
);

    // Condition select per branch opcode; non-branch opcodes never take.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_B, OP_BL, OP_BR: taken = 1'b1;
            OP_BLTZ:            taken = neg_flag;
            OP_BZ:              taken = zero_flag;
            OP_BNZ:             taken = ~zero_flag;
            OP_BCY:             taken = carry_flag;
            OP_BNCY:            taken = ~carry_flag;
            default:            taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/kgp_control_fsm.sv
// Multi-cycle KGP-RISC control unit: sequences fetch..writeback around BRAM
// latency and drives every datapath control strobe.
module kgp_control_fsm
    import kgp_isa_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    kgp_control_fsm_if.master  ctrl
);

    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

    state_t     state_r, state_s;
    logic [2:0] cnt_r, cnt_s;
    logic [4:0] op_r, fn_r;
    logic       taken_s;
    logic       alu_class_s, mem_class_s, is_lw_s;

    logic [2:0] alu_op_s;
    logic [1:0] alu_src_s, pc_src_s;
    logic       alu_frc_s, br_link_s, mem_to_reg_s, mem_read_s, mem_write_s;
    logic       reg_write_s, branch_s, pc_write_s, ir_write_s, flag_write_s, illegal_s;

    kgp_branch_cond u_branch_cond (
        .opcode     (op_r),
        .zero_flag  (ctrl.zeroFlag),
        .neg_flag   (ctrl.negFlag),
        .carry_flag (ctrl.carryFlag),
        .taken      (taken_s)
    );

    assign alu_class_s = (op_r == OP_RTYPE) || (op_r == OP_ADDI) || (op_r == OP_COMPI);
    assign mem_class_s = (op_r == OP_LW) || (op_r == OP_SW);
    assign is_lw_s     = (op_r == OP_LW);

    // State, wait counter and the instruction fields captured in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
            cnt_r   <= 3'd0;
            op_r    <= 5'd0;
            fn_r    <= 5'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (state_r == ST_DECODE) begin
                op_r <= ctrl.opcode;
                fn_r <= ctrl.funccode;
            end else begin
                op_r <= op_r;
                fn_r <= fn_r;
            end
        end
    end

    // Next-state and control decode; outputs follow the state register so an
    // asynchronous reset clears every strobe in the same cycle.
    always_comb begin
        state_s      = state_r;
        cnt_s        = 3'd0;
        alu_op_s     = ALU_ADD;
        alu_src_s    = SRC_RT;
        pc_src_s     = PC_INC;
        alu_frc_s    = 1'b0;
        br_link_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        branch_s     = 1'b0;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        flag_write_s = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            ST_FETCH: state_s = ST_FWAIT;
            ST_FWAIT: begin
                if (cnt_r == LAST_WAIT) begin
                    ir_write_s = 1'b1;
                    state_s    = ST_DECODE;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_DECODE: begin
                if (is_legal(ctrl.opcode, ctrl.funccode)) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (alu_class_s) begin
                    if (op_r == OP_RTYPE) begin
                        alu_op_s  = rtype_alu_op(fn_r);
                        alu_src_s = rtype_alu_src(fn_r);
                    end else begin
                        alu_op_s  = (op_r == OP_ADDI) ? ALU_ADD : ALU_COMP;
                        alu_src_s = SRC_IMM;
                    end
                    flag_write_s = 1'b1;
                    state_s      = ST_WB;
                end else if (mem_class_s) begin
                    alu_frc_s = 1'b1;
                    alu_src_s = SRC_IMM;
                    state_s   = ST_MEM;
                end else begin
                    branch_s = taken_s;
                    if (op_r == OP_BR) begin
                        pc_src_s = PC_REG;
                    end else if (taken_s) begin
                        pc_src_s = PC_LABEL;
                    end else begin
                        pc_src_s = PC_INC;
                    end
                    // bl retires in WB, where the link write and PC update happen together.
                    if (op_r == OP_BL) begin
                        state_s = ST_WB;
                    end else begin
                        pc_write_s = 1'b1;
                        state_s    = ST_FETCH;
                    end
                end
            end
            ST_MEM: begin
                alu_frc_s   = 1'b1;
                alu_src_s   = SRC_IMM;
                mem_read_s  = is_lw_s;
                mem_write_s = ~is_lw_s;
                state_s     = ST_MWAIT;
            end
            ST_MWAIT: begin
                alu_frc_s   = 1'b1;
                alu_src_s   = SRC_IMM;
                mem_read_s  = is_lw_s;
                mem_write_s = ~is_lw_s;
                if (cnt_r == LAST_WAIT) begin
                    if (is_lw_s) begin
                        state_s = ST_WB;
                    end else begin
                        pc_write_s = 1'b1;
                        state_s    = ST_FETCH;
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = is_lw_s;
                pc_write_s   = 1'b1;
                if (op_r == OP_BL) begin
                    br_link_s = 1'b1;
                    pc_src_s  = PC_LABEL;
                end else begin
                    pc_src_s  = PC_INC;
                end
                state_s = ST_FETCH;
            end
            ST_TRAP: begin
                illegal_s = 1'b1;
                state_s   = ST_TRAP;
            end
            default: state_s = ST_FETCH;
        endcase
    end

    assign ctrl.ALUResOp  = alu_op_s;
    assign ctrl.ALUSrc    = alu_src_s;
    assign ctrl.ALUFrc    = alu_frc_s;
    assign ctrl.brLink    = br_link_s;
    assign ctrl.memToReg  = mem_to_reg_s;
    assign ctrl.memRead   = mem_read_s;
    assign ctrl.memWrite  = mem_write_s;
    assign ctrl.regWrite  = reg_write_s;
    assign ctrl.branch    = branch_s;
    assign ctrl.pcSrc     = pc_src_s;
    assign ctrl.pcWrite   = pc_write_s;
    assign ctrl.irWrite   = ir_write_s;
    assign ctrl.flagWrite = flag_write_s;
    assign ctrl.illegal   = illegal_s;

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Scoreboard bench for kgp_control_fsm: per-cycle expected control vectors are
// queued per instruction and compared against two instances (MEM_LAT 1 and 2).
module tb_kgp_control_fsm;
  import kgp_isa_pkg::*;

  logic clk = 1'b0;
  logic rst1, rst2;
  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  kgp_control_fsm_if bus1();
  kgp_control_fsm_if bus2();

  kgp_control_fsm #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst1), .ctrl(bus1.master));
  kgp_control_fsm #(.MEM_LAT(2)) dut2 (.clk(clk), .rst(rst2), .ctrl(bus2.master));

  // {ALUResOp, ALUSrc, ALUFrc, brLink, memToReg, memRead, memWrite, regWrite,
  //  branch, pcSrc, pcWrite, irWrite, flagWrite, illegal}
  function automatic logic [17:0] v(input logic [2:0] aop, input logic [1:0] src,
      input logic frc, input logic link, input logic m2r, input logic mrd, input logic mwr,
      input logic rw, input logic br, input logic [1:0] pcs, input logic pcw,
      input logic irw, input logic fw, input logic ill);
    return {aop, src, frc, link, m2r, mrd, mwr, rw, br, pcs, pcw, irw, fw, ill};
  endfunction

  function automatic logic [17:0] obs(input int sel);
    if (sel == 1)
      return {bus1.ALUResOp, bus1.ALUSrc, bus1.ALUFrc, bus1.brLink, bus1.memToReg,
              bus1.memRead, bus1.memWrite, bus1.regWrite, bus1.branch, bus1.pcSrc,
              bus1.pcWrite, bus1.irWrite, bus1.flagWrite, bus1.illegal};
    else
      return {bus2.ALUResOp, bus2.ALUSrc, bus2.ALUFrc, bus2.brLink, bus2.memToReg,
              bus2.memRead, bus2.memWrite, bus2.regWrite, bus2.branch, bus2.pcSrc,
              bus2.pcWrite, bus2.irWrite, bus2.flagWrite, bus2.illegal};
  endfunction

  task automatic set_in(input int sel, input logic [4:0] op, input logic [4:0] fn,
                        input logic z, input logic n, input logic c);
    if (sel == 1) begin
      bus1.opcode = op; bus1.funccode = fn;
      bus1.zeroFlag = z; bus1.negFlag = n; bus1.carryFlag = c;
    end else begin
      bus2.opcode = op; bus2.funccode = fn;
      bus2.zeroFlag = z; bus2.negFlag = n; bus2.carryFlag = c;
    end
  endtask

  task automatic push_fetch(input int lat);
    exp_q.push_back(18'd0);
    for (int i = 0; i < lat - 1; i++) exp_q.push_back(18'd0);
    exp_q.push_back(v(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(18'd0);
  endtask

  task automatic push_alu(input int lat, input logic [2:0] aop, input logic [1:0] src);
    push_fetch(lat);
    exp_q.push_back(v(aop, src, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(v(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_mem(input int lat, input logic is_lw);
    push_fetch(lat);
    exp_q.push_back(v(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < lat; i++)
      exp_q.push_back(v(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, is_lw, ~is_lw, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    if (is_lw) begin
      exp_q.push_back(v(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(v(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(v(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic push_br(input int lat, input logic tk, input logic [1:0] pcs, input logic is_bl);
    push_fetch(lat);
    exp_q.push_back(v(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tk, pcs, ~is_bl, 1'b0, 1'b0, 1'b0));
    if (is_bl)
      exp_q.push_back(v(3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run_q(input int sel, input string name);
    logic [17:0] e, a;
    int cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      a = obs(sel);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, a, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int sel);
    logic [17:0] a;
    if (sel == 1) rst1 = 1'b1; else rst2 = 1'b1;
    #1;
    a = obs(sel);
    checks++;
    if (a !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs dut%0d: got %b expected all zero", sel, a);
    end
    @(negedge clk);
    if (sel == 1) rst1 = 1'b0; else rst2 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    set_in(1, OP_RTYPE, FN_ADD, 1'b0, 1'b0, 1'b0);
    set_in(2, OP_RTYPE, FN_ADD, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    do_reset(1);
    do_reset(2);
    do_reset(1);
  endtask

  task automatic test_alu();
    logic [4:0] t_op [12] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE,
                              OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_COMPI};
    logic [4:0] t_fn [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd0};
    logic [2:0] t_ao [12] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101,
                              3'b100, 3'b101, 3'b110, 3'b110, 3'b000, 3'b001};
    logic [1:0] t_sr [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10,
                              2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 12; i++) begin
      set_in(1, t_op[i], t_fn[i], 1'b0, 1'b0, 1'b0);
      push_alu(1, t_ao[i], t_sr[i]);
      run_q(1, $sformatf("alu_%0d", i));
    end
  endtask

  task automatic test_mem();
    set_in(1, OP_LW, 5'd0, 1'b0, 1'b0, 1'b0);
    push_mem(1, 1'b1); run_q(1, "lw_lat1");
    set_in(1, OP_SW, 5'd0, 1'b0, 1'b0, 1'b0);
    push_mem(1, 1'b0); run_q(1, "sw_lat1");
    do_reset(2);
    set_in(2, OP_LW, 5'd0, 1'b0, 1'b0, 1'b0);
    push_mem(2, 1'b1); run_q(2, "lw_lat2");
    set_in(2, OP_SW, 5'd0, 1'b0, 1'b0, 1'b0);
    push_mem(2, 1'b0); run_q(2, "sw_lat2");
    set_in(2, OP_RTYPE, FN_XOR, 1'b0, 1'b0, 1'b0);
    push_alu(2, 3'b011, 2'b00); run_q(2, "xor_lat2");
  endtask

  task automatic do_branch(input logic [4:0] op, input logic z, input logic n, input logic c,
                           input logic tk, input logic [1:0] pcs, input string name);
    set_in(1, op, 5'd0, z, n, c);
    push_br(1, tk, pcs, 1'b0);
    run_q(1, name);
  endtask

  task automatic test_branch();
    do_branch(OP_BZ,   1'b1, 1'b0, 1'b0, 1'b1, 2'b01, "bz_taken");
    do_branch(OP_BZ,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "bz_not");
    do_branch(OP_B,    1'b0, 1'b0, 1'b0, 1'b1, 2'b01, "b");
    do_branch(OP_BR,   1'b0, 1'b0, 1'b0, 1'b1, 2'b10, "br");
    do_branch(OP_BLTZ, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, "bltz_taken");
    do_branch(OP_BLTZ, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "bltz_not");
    do_branch(OP_BNZ,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01, "bnz_taken");
    do_branch(OP_BNZ,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, "bnz_not");
    do_branch(OP_BCY,  1'b0, 1'b0, 1'b1, 1'b1, 2'b01, "bcy_taken");
    do_branch(OP_BCY,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, "bcy_not");
    do_branch(OP_BNCY, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, "bncy_taken");
    do_branch(OP_BNCY, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "bncy_not");
    set_in(1, OP_BL, 5'd0, 1'b0, 1'b0, 1'b0);
    push_br(1, 1'b1, 2'b01, 1'b1);
    run_q(1, "bl");
  endtask

  // Flags toggle outside EXEC and the opcode changes after DECODE; neither may matter.
  task automatic test_flag_sample();
    logic [17:0] e, a;
    push_br(1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      set_in(1, (i >= 3) ? 5'b11111 : OP_BZ, 5'd0, (i == 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      #1;
      a = obs(1);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL flag_sample cycle %0d: got %b expected %b", i, a, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal(input logic [4:0] op, input logic [4:0] fn, input string name);
    logic [17:0] a;
    logic [17:0] ill;
    int pcw_seen = 0;
    ill = v(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1);
    set_in(1, op, fn, 1'b0, 1'b0, 1'b0);
    push_fetch(1);
    run_q(1, name);
    set_in(1, OP_RTYPE, FN_ADD, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      #1;
      a = obs(1);
      if (a[3] !== 1'b0) pcw_seen++;
      checks++;
      if (a !== ill) begin
        errors++;
        $display("FAIL %s_trap cycle %0d: got %b expected %b", name, i, a, ill);
      end
      @(negedge clk);
    end
    checks++;
    if (pcw_seen != 0) begin
      errors++;
      $display("FAIL %s_no_pcwrite: got %0d pcWrite cycles expected 0", name, pcw_seen);
    end
    do_reset(1);
    push_alu(1, 3'b000, 2'b00);
    run_q(1, {name, "_recover"});
  endtask

  task automatic test_reset_mid_write();
    do_reset(2);
    set_in(2, OP_SW, 5'd0, 1'b0, 1'b0, 1'b0);
    push_fetch(2);
    exp_q.push_back(v(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(v(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    run_q(2, "sw_to_mwait");
    #1;
    checks++;
    if (bus2.memWrite !== 1'b1) begin
      errors++;
      $display("FAIL mwait_memwrite: got %b expected 1", bus2.memWrite);
    end
    rst2 = 1'b1;
    #1;
    checks++;
    if (bus2.memWrite !== 1'b0) begin
      errors++;
      $display("FAIL async_memwrite_drop: got %b expected 0", bus2.memWrite);
    end
    checks++;
    if (obs(2) !== 18'd0) begin
      errors++;
      $display("FAIL async_all_zero: got %b expected all zero", obs(2));
    end
    @(negedge clk);
    rst2 = 1'b0;
    set_in(2, OP_RTYPE, FN_AND, 1'b0, 1'b0, 1'b0);
    push_alu(2, 3'b010, 2'b00);
    run_q(2, "restart_after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_flag_sample();
    test_illegal(5'b11111, 5'd0, "bad_opcode");
    test_illegal(OP_RTYPE, 5'b11111, "bad_funccode");
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
